// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO with per-pin direction, set/clr/toggle, synchronised inputs and edge IRQs.
// Writes land on the strobe edge, reads return one cycle later; no backpressure, a strobe is accepted every cycle.
module gpio_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [31:0]      addr,
  input  logic [31:0]      in_data,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] OFF_DATA_OUT = 4'd0;
  localparam logic [3:0] OFF_DIR      = 4'd1;
  localparam logic [3:0] OFF_SET      = 4'd2;
  localparam logic [3:0] OFF_CLR      = 4'd3;
  localparam logic [3:0] OFF_TOGGLE   = 4'd4;
  localparam logic [3:0] OFF_DATA_IN  = 4'd5;
  localparam logic [3:0] OFF_IRQ_EN   = 4'd6;
  localparam logic [3:0] OFF_IRQ_STS  = 4'd7;
  localparam logic [3:0] OFF_EDGE_SEL = 4'd8;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_status;
  logic [WIDTH-1:0] edge_sel;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  logic             hit;
  logic             wr_hit;
  logic [3:0]       off;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign hit         = (addr[31:6] == BASE_ADDR[31:6]);
  assign off         = addr[5:2];
  assign wr_hit      = wr_en && hit;
  assign wdat        = in_data[WIDTH-1:0];
  assign sync_q      = sync[SYNC_STAGES-1];
  assign unused_bits = ^{addr[1:0], in_data};

  // Edge detect compares the last synchronised stage against its one-cycle history.
  assign evt = irq_en & ((edge_sel & sync_q & ~prev) | (~edge_sel & ~sync_q & prev));
  assign w1c = (wr_hit && off == OFF_IRQ_STS) ? wdat : '0;

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (off)
        OFF_DATA_OUT: rd_mux[WIDTH-1:0] = data_out;
        OFF_DIR:      rd_mux[WIDTH-1:0] = dir;
        OFF_DATA_IN:  rd_mux[WIDTH-1:0] = sync_q;
        OFF_IRQ_EN:   rd_mux[WIDTH-1:0] = irq_en;
        OFF_IRQ_STS:  rd_mux[WIDTH-1:0] = irq_status;
        OFF_EDGE_SEL: rd_mux[WIDTH-1:0] = edge_sel;
        default:      rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      irq_status <= '0;
      edge_sel   <= '0;
      sync       <= '0;
      prev       <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], gpio_in};
      prev <= sync_q;
      if (wr_hit) begin
        case (off)
          OFF_DATA_OUT: data_out <= wdat;
          OFF_DIR:      dir      <= wdat;
          OFF_SET:      data_out <= data_out | wdat;
          OFF_CLR:      data_out <= data_out & ~wdat;
          OFF_TOGGLE:   data_out <= data_out ^ wdat;
          OFF_IRQ_EN:   irq_en   <= wdat;
          OFF_EDGE_SEL: edge_sel <= wdat;
          default: ;
        endcase
      end
      // A coincident event re-sets a bit that the same write clears.
      irq_status <= (irq_status & ~w1c) | evt;
      rd_valid   <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

  assign gpio_out = data_out;
  assign gpio_oe  = dir;
  assign irq      = |(irq_status & irq_en);

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: 32-bit instance plus an 8-bit instance sharing the bus.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] in_data = '0;
  logic [31:0] gpio_in = '0;

  logic [31:0] rd_data, gpio_out, gpio_oe;
  logic        rd_valid, irq;
  logic [31:0] rd_data8;
  logic [7:0]  gpio_out8, gpio_oe8;
  logic        rd_valid8, irq8;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] sb[$];
  logic [31:0] exp;
  logic [31:0] model;

  always #5 clk = ~clk;

  gpio_bank #(.WIDTH(32), .BASE_ADDR(32'd1024), .SYNC_STAGES(2)) u32 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .in_data(in_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_bank #(.WIDTH(8), .BASE_ADDR(32'd1024), .SYNC_STAGES(2)) u8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .in_data(in_data),
    .rd_data(rd_data8), .rd_valid(rd_valid8), .gpio_in(gpio_in[7:0]),
    .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
  );

  function automatic logic [31:0] ra(input int o);
    return 32'd1024 + 32'(o * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; in_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Expected value is queued at issue; the caller pops it when rd_valid is due.
  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e);
    sb.push_back(e);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (gpio_out !== 32'h0) $display("FAIL reset_gpio_out: got %h want 0", gpio_out); else passed++;
    checks++; if (gpio_oe !== 32'h0) $display("FAIL reset_gpio_oe: got %h want 0", gpio_oe); else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
    checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passed++;
    bus_rd(ra(1), 32'h0);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL reset_rd_dir: got %h/%b want %h/1", rd_data, rd_valid, exp); else passed++;
    tick();
    checks++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); else passed++;
  endtask

  task automatic test_data_ops();
    bus_wr(ra(0), 32'h0000_00F0); model = 32'h0000_00F0;
    checks++; if (gpio_out !== model) $display("FAIL data_out_wr: got %h want %h", gpio_out, model); else passed++;
    bus_wr(ra(2), 32'h0000_000F); model = model | 32'h0F;
    checks++; if (gpio_out !== model) $display("FAIL set: got %h want %h", gpio_out, model); else passed++;
    bus_wr(ra(3), 32'h0000_0030); model = model & ~32'h30;
    checks++; if (gpio_out !== model) $display("FAIL clr: got %h want %h", gpio_out, model); else passed++;
    bus_wr(ra(4), 32'h0000_0101); model = model ^ 32'h101;
    checks++; if (gpio_out !== 32'h0000_01CE) $display("FAIL toggle: got %h want 000001ce", gpio_out); else passed++;
    bus_rd(ra(0), model);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL rd_data_out: got %h/%b want %h/1", rd_data, rd_valid, exp); else passed++;
    bus_rd(ra(2), 32'h0);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL rd_set_wo: got %h want %h", rd_data, exp); else passed++;
    // Read and write of the same register in one cycle returns the old contents.
    sb.push_back(model);
    rd_en = 1'b1; wr_en = 1'b1; addr = ra(0); in_data = 32'h1234_5678;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    model = 32'h1234_5678;
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL rd_wr_same: got %h want %h", rd_data, exp); else passed++;
    checks++; if (gpio_out !== model) $display("FAIL rd_wr_same_out: got %h want %h", gpio_out, model); else passed++;
  endtask

  task automatic test_dir();
    bus_wr(ra(1), 32'hFFFF_FFFF);
    checks++; if (gpio_oe !== 32'hFFFF_FFFF) $display("FAIL oe32: got %h want ffffffff", gpio_oe); else passed++;
    checks++; if (gpio_oe8 !== 8'hFF) $display("FAIL oe8: got %h want ff", gpio_oe8); else passed++;
    bus_rd(ra(1), 32'hFFFF_FFFF);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL rd_dir32: got %h want %h", rd_data, exp); else passed++;
    checks++; if (rd_valid8 !== 1'b1 || rd_data8 !== 32'h0000_00FF) $display("FAIL rd_dir8: got %h/%b want 000000ff/1", rd_data8, rd_valid8); else passed++;
    bus_wr(ra(1), 32'h0);
  endtask

  task automatic test_irq();
    bus_wr(ra(6), 32'h1);
    bus_wr(ra(8), 32'h1);
    gpio_in[0] = 1'b1;
    tick(); tick();
    checks++; if (irq !== 1'b0) $display("FAIL irq_early: got %b want 0", irq); else passed++;
    tick();
    checks++; if (irq !== 1'b1) $display("FAIL irq_rise: got %b want 1", irq); else passed++;
    bus_rd(ra(7), 32'h1);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL rd_status: got %h want %h", rd_data, exp); else passed++;
    bus_rd(ra(5), 32'h1);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL rd_data_in: got %h want %h", rd_data, exp); else passed++;
    bus_wr(ra(7), 32'h1);
    checks++; if (irq !== 1'b0) $display("FAIL irq_w1c: got %b want 0", irq); else passed++;
    gpio_in[0] = 1'b0;
    repeat (4) tick();
    checks++; if (irq !== 1'b0) $display("FAIL irq_fall_ignored: got %b want 0", irq); else passed++;
    bus_rd(ra(7), 32'h0);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL rd_status_fall: got %h want %h", rd_data, exp); else passed++;
  endtask

  task automatic test_w1c_race();
    gpio_in[0] = 1'b1;
    repeat (3) tick();
    gpio_in[0] = 1'b0;
    repeat (4) tick();
    gpio_in[0] = 1'b1;
    tick(); tick();
    bus_wr(ra(7), 32'h1);
    checks++; if (irq !== 1'b1) $display("FAIL race_irq: got %b want 1", irq); else passed++;
    bus_rd(ra(7), 32'h1);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL race_status: got %h want %h", rd_data, exp); else passed++;
    bus_wr(ra(6), 32'h0);
    checks++; if (irq !== 1'b0) $display("FAIL mask_irq: got %b want 0", irq); else passed++;
    bus_rd(ra(7), 32'h1);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL mask_status_kept: got %h want %h", rd_data, exp); else passed++;
    bus_wr(ra(7), 32'h1);
    bus_wr(ra(8), 32'h0);
    bus_wr(ra(6), 32'h1);
    gpio_in[0] = 1'b0;
    repeat (3) tick();
    checks++; if (irq !== 1'b1) $display("FAIL irq_falling_sel: got %b want 1", irq); else passed++;
    bus_wr(ra(7), 32'h1);
    bus_wr(ra(6), 32'h0);
  endtask

  task automatic test_miss();
    bus_wr(32'h0000_0800, 32'h0000_DEAD);
    checks++; if (gpio_out !== model) $display("FAIL miss_wr: got %h want %h", gpio_out, model); else passed++;
    bus_wr(ra(10), 32'hFFFF_FFFF);
    checks++; if (gpio_out !== model || gpio_oe !== 32'h0) $display("FAIL unmapped_wr: got %h/%h want %h/0", gpio_out, gpio_oe, model); else passed++;
    bus_rd(32'h0000_0800, 32'h0);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL miss_rd: got %h/%b want %h/1", rd_data, rd_valid, exp); else passed++;
    bus_rd(ra(10), 32'h0);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL off10_rd: got %h/%b want %h/1", rd_data, rd_valid, exp); else passed++;
    bus_rd(32'd1024 + 32'd64, 32'h0);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL miss_above_rd: got %h want %h", rd_data, exp); else passed++;
    bus_rd(32'd1024 + 32'd3, model);
    exp = sb.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp) $display("FAIL byte_lane_rd: got %h want %h", rd_data, exp); else passed++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = ra(1); in_data = 32'h55;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b want 0", rd_valid); else passed++;
    checks++; if (gpio_out !== 32'h0 || gpio_oe !== 32'h0) $display("FAIL rst_override: got %h/%h want 0/0", gpio_out, gpio_oe); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset();
    test_data_ops();
    test_dir();
    test_irq();
    test_w1c_race();
    test_miss();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
